fsm_control_mc: RTL
===================

# fsm_control_mc

Parametrised multicycle control unit that sequences fetch, decode, execute, memory and writeback for the CPU datapath. It adds three things to the fixed-timing controller: variable-latency memory via a `mem_ready` handshake with a timeout trap, a multi-cycle ALU path (MUL) via `alu_start`/`alu_done`, and a debug `stall` freeze. It sits between the instruction register/zero flag and every datapath mux and write enable.

## Interface
- `OPCODE_SIZE`, 4: opcode width. Opcode values come from the shared instruction constants, plus the new `MUL_INSTR`.
- `ALUOP_W`, 5: ALU operation field width. `ADD`, `SUB` and `MUL` come from the shared constants.
- `MEM_TIMEOUT`, 16: consecutive not-ready cycles before trapping. A value of 0 disables the timeout.
- `CNT_W`, 32: width of the performance counters.
- `clk  in  1`: clock, rising edge.
- `reboot_n  in  1`: asynchronous, active-low reset.
- `opcode  in  OPCODE_SIZE`: current instruction opcode.
- `zero_flag  in  1`: ALU zero result.
- `mem_ready  in  1`: memory has completed the current access.
- `alu_done  in  1`: one-cycle pulse marking the end of a multi-cycle ALU operation.
- `stall  in  1`: debug freeze request.
- Datapath control outputs (all `out`):
  - `MemRead`, `MemWrite`, `ALUSrcA`, `IorD`, `IRWrite`: 1 bit each.
  - `ALUSrcB`: 2 bits.
  - `ALUOp`: `ALUOP_W` bits.
  - `PCWrite`: 1 bit.
  - `PCSource`: 2 bits.
  - `RegWrite`, `MemtoReg`, `writeback_alu_enable`: 1 bit each.
- `alu_start  out  1`: one-cycle pulse that starts a MUL.
- `illegal_op  out  1`: one-cycle pulse on an undefined opcode.
- `bus_error  out  1`: sticky; set on memory timeout.
- `state_o  out  4`: current state.
- `retired_count  out  CNT_W`: retired-instruction counter.
- `cycle_count  out  CNT_W`: non-stalled cycle counter.

## Operation
- **State encoding:** IF=0, ID=1, EXEC=2, EXEC_WAIT=3, WB_ALU=4, MAC=5, WB_MEM=6, BRANCH=7, JUMP=8, TRAP=9. Codes 10–15 go to IF.
- **Reset values:** while `reboot_n` is low:
  - every output is 0, except `state_o`=0 (IF);
  - the wait counter, done flag and perf counters are all 0.
- **Default outputs:** all control outputs are 0 unless listed below.
- **IF:**
  - Asserts `MemRead`=1, `IorD`=0, `ALUSrcB`=01, `ALUOp`=`ADD`.
  - `IRWrite` and `PCWrite` are asserted only in the cycle `mem_ready`=1; that cycle also moves to ID. Otherwise the FSM stays in IF.
- **ID:**
  - ADD/SUB go to EXEC. MUL goes to EXEC.
  - LOAD/STORE go to MAC.
  - JUMP goes to JUMP.
  - BEQ/BNE go to BRANCH.
  - Any other opcode pulses `illegal_op` and returns to IF.
- **EXEC:**
  - Asserts `ALUSrcA`=1, `ALUSrcB`=00, and `ALUOp` = `ADD`, `SUB` or `MUL`.
  - ADD/SUB go to WB_ALU.
  - MUL pulses `alu_start` and goes to EXEC_WAIT.
- **EXEC_WAIT:** holds `ALUOp`=`MUL` and goes to WB_ALU once `alu_done` is seen, either live or via the done flag.
- **WB_ALU:** asserts `RegWrite`=1, `writeback_alu_enable`=1, `MemtoReg`=0, then goes to IF.
- **MAC:**
  - Asserts `ALUSrcA`=1, `ALUSrcB`=10, `ALUOp`=`ADD`, `IorD`=1, plus `MemRead` (LOAD) or `MemWrite` (STORE).
  - Leaves only on `mem_ready`=1: LOAD goes to WB_MEM, STORE goes to IF.
- **WB_MEM:** asserts `RegWrite`=1, `MemtoReg`=1, then goes to IF.
- **BRANCH:**
  - Asserts `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=`SUB`, `PCSource`=01.
  - `PCWrite` = `zero_flag` for BEQ, `!zero_flag` for BNE.
  - Then goes to IF.
- **JUMP:** asserts `PCWrite`=1, `PCSource`=10, then goes to IF.
- **Memory timeout:**
  - The wait counter increments each IF/MAC cycle with `mem_ready`=0. It clears on state entry or on `mem_ready`=1.
  - When it reaches `MEM_TIMEOUT`, the next state is TRAP.
- **TRAP:** `bus_error`=1, all enables 0. The FSM stays there until reset.
- **Stall:**
  - While `stall`=1, the state and wait counter hold.
  - `MemRead`, `MemWrite`, `IRWrite`, `PCWrite`, `RegWrite`, `alu_start` and `writeback_alu_enable` are forced to 0; mux selects still follow the state.
  - `stall` overrides `mem_ready`: a ready seen during a stall is ignored, and memory must re-assert it.
  - `alu_done` seen during a stall sets the done flag. The flag clears on leaving EXEC_WAIT.
- **Retirement:** counted on any transition into IF from WB_ALU, WB_MEM, MAC (store), BRANCH or JUMP. Illegal-opcode returns and reset do not count.

## Timing
- **State update:** registered on `posedge clk`. `reboot_n` acts asynchronously on its falling edge; release is synchronous.
- **Outputs:** combinational from the state and inputs (Mealy on `mem_ready`, `zero_flag`, `stall`).
- **Latency with zero wait states:**

  | Instruction | Cycles |
  |---|---|
  | ADD/SUB | 4 |
  | LOAD | 4 |
  | STORE | 3 |
  | BEQ/BNE | 3 |
  | JUMP | 3 |
  | MUL | 4 + N, where N = cycles from `alu_start` to `alu_done` |

- **Wait states:** each cycle of `mem_ready`=0 in IF or MAC adds one cycle.
- **Trap timing:** TRAP is entered on the clock edge after `MEM_TIMEOUT` consecutive not-ready cycles.
- **Counter wrap:** both counters wrap modulo 2^`CNT_W`.

## Configuration
- **`FSM_CONTROL_PERF_CNT_EN` defined:** `retired_count` and `cycle_count` are implemented.
  - `cycle_count` increments every non-stalled cycle outside TRAP.
- **`FSM_CONTROL_PERF_CNT_EN` undefined:** both ports remain but are tied to 0, and no counter flops are built.

## Test plan
- **ADD, `mem_ready` tied 1:**
  - `state_o` sequence is 0,1,2,4,0.
  - `RegWrite`=1 only in state 4.
  - `retired_count` goes 0→1.
- **LOAD with `mem_ready` low for 3 MAC cycles:**
  - MAC lasts 4 cycles with `MemRead`=1, `IorD`=1.
  - WB_MEM then asserts `MemtoReg`=1.
- **MUL with `alu_done` 5 cycles after `alu_start`:**
  - Exactly one `alu_start` pulse.
  - EXEC_WAIT lasts 5 cycles, then WB_ALU.
- **BNE with `zero_flag`=1, then BEQ with `zero_flag`=1:**
  - BNE: `PCWrite`=0 in BRANCH.
  - BEQ: `PCWrite`=1 with `PCSource`=01.
- **`MEM_TIMEOUT`=16, `mem_ready` held 0 in IF:**
  - State is 9 after 16 cycles, and `bus_error`=1 stays set.
  - Asserting `reboot_n`=0 mid-cycle immediately gives `state_o`=0 and all outputs 0.
- **Stall and illegal opcode:**
  - `stall`=1 for 4 cycles in IF with `mem_ready`=1: state holds and `IRWrite`=0; the fetch completes the cycle after the stall drops.
  - Opcode 4'hF in ID: one `illegal_op` pulse, return to IF, no retire.

Source files
------------

// File: rtl/fsm_control_mc.sv
// Multicycle CPU control FSM: fetch/decode/execute/memory/writeback with a mem_ready
// handshake and timeout trap, a MUL start/done handshake and a debug stall freeze.
// Optional perf counters are built only when FSM_CONTROL_PERF_CNT_EN is defined.
module fsm_control_mc #(
  parameter int OPCODE_SIZE = 4,
  parameter int ALUOP_W     = 5,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32,
  parameter logic [OPCODE_SIZE-1:0] ADD_INSTR   = 'd0,
  parameter logic [OPCODE_SIZE-1:0] SUB_INSTR   = 'd1,
  parameter logic [OPCODE_SIZE-1:0] LOAD_INSTR  = 'd2,
  parameter logic [OPCODE_SIZE-1:0] STORE_INSTR = 'd3,
  parameter logic [OPCODE_SIZE-1:0] BEQ_INSTR   = 'd4,
  parameter logic [OPCODE_SIZE-1:0] BNE_INSTR   = 'd5,
  parameter logic [OPCODE_SIZE-1:0] JUMP_INSTR  = 'd6,
  parameter logic [OPCODE_SIZE-1:0] MUL_INSTR   = 'd7,
  parameter logic [ALUOP_W-1:0]     ADD         = 'd2,
  parameter logic [ALUOP_W-1:0]     SUB         = 'd6,
  parameter logic [ALUOP_W-1:0]     MUL         = 'd8
) (
  input  logic                   clk,
  input  logic                   reboot_n,
  input  logic [OPCODE_SIZE-1:0] opcode,
  input  logic                   zero_flag,
  input  logic                   mem_ready,
  input  logic                   alu_done,
  input  logic                   stall,
  output logic                   MemRead,
  output logic                   MemWrite,
  output logic                   ALUSrcA,
  output logic                   IorD,
  output logic                   IRWrite,
  output logic [1:0]             ALUSrcB,
  output logic [ALUOP_W-1:0]     ALUOp,
  output logic                   PCWrite,
  output logic [1:0]             PCSource,
  output logic                   RegWrite,
  output logic                   MemtoReg,
  output logic                   writeback_alu_enable,
  output logic                   alu_start,
  output logic                   illegal_op,
  output logic                   bus_error,
  output logic [3:0]             state_o,
  output logic [CNT_W-1:0]       retired_count,
  output logic [CNT_W-1:0]       cycle_count
);

  localparam int WCNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

  typedef enum logic [3:0] {
    S_IF        = 4'd0,
    S_ID        = 4'd1,
    S_EXEC      = 4'd2,
    S_EXEC_WAIT = 4'd3,
    S_WB_ALU    = 4'd4,
    S_MAC       = 4'd5,
    S_WB_MEM    = 4'd6,
    S_BRANCH    = 4'd7,
    S_JUMP      = 4'd8,
    S_TRAP      = 4'd9
  } state_t;

  state_t            state_q, state_d;
  logic [WCNT_W-1:0] wait_q, wait_d;
  logic              done_q, done_d;
  logic              retire;
  logic              timeout_hit;

  // Trap fires on the edge that closes the MEM_TIMEOUT-th consecutive not-ready cycle.
  assign timeout_hit = (MEM_TIMEOUT != 0) && !mem_ready &&
                       (wait_q == WCNT_W'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk or negedge reboot_n) begin
    if (!reboot_n) begin
      state_q <= S_IF;
      wait_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d              = state_q;
    retire               = 1'b0;
    MemRead              = 1'b0;
    MemWrite             = 1'b0;
    ALUSrcA              = 1'b0;
    IorD                 = 1'b0;
    IRWrite              = 1'b0;
    ALUSrcB              = 2'b00;
    ALUOp                = '0;
    PCWrite              = 1'b0;
    PCSource             = 2'b00;
    RegWrite             = 1'b0;
    MemtoReg             = 1'b0;
    writeback_alu_enable = 1'b0;
    alu_start            = 1'b0;
    illegal_op           = 1'b0;
    bus_error            = 1'b0;

    case (state_q)
      S_IF: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        ALUOp   = ADD;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_ID;
        end else if (timeout_hit) begin
          state_d = S_TRAP;
        end
      end
      S_ID: begin
        case (opcode)
          ADD_INSTR, SUB_INSTR, MUL_INSTR: state_d = S_EXEC;
          LOAD_INSTR, STORE_INSTR:         state_d = S_MAC;
          JUMP_INSTR:                      state_d = S_JUMP;
          BEQ_INSTR, BNE_INSTR:            state_d = S_BRANCH;
          default: begin
            illegal_op = 1'b1;
            state_d    = S_IF;
          end
        endcase
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b00;
        if (opcode == MUL_INSTR) begin
          ALUOp     = MUL;
          alu_start = 1'b1;
          state_d   = S_EXEC_WAIT;
        end else begin
          ALUOp   = (opcode == SUB_INSTR) ? SUB : ADD;
          state_d = S_WB_ALU;
        end
      end
      S_EXEC_WAIT: begin
        ALUOp = MUL;
        if (alu_done || done_q) state_d = S_WB_ALU;
      end
      S_WB_ALU: begin
        RegWrite             = 1'b1;
        writeback_alu_enable = 1'b1;
        state_d              = S_IF;
        retire               = 1'b1;
      end
      S_MAC: begin
        ALUSrcA  = 1'b1;
        ALUSrcB  = 2'b10;
        ALUOp    = ADD;
        IorD     = 1'b1;
        MemRead  = (opcode == LOAD_INSTR);
        MemWrite = (opcode == STORE_INSTR);
        if (mem_ready) begin
          if (opcode == LOAD_INSTR) begin
            state_d = S_WB_MEM;
          end else begin
            state_d = S_IF;
            retire  = 1'b1;
          end
        end else if (timeout_hit) begin
          state_d = S_TRAP;
        end
      end
      S_WB_MEM: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        state_d  = S_IF;
        retire   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUSrcB  = 2'b00;
        ALUOp    = SUB;
        PCSource = 2'b01;
        PCWrite  = (opcode == BNE_INSTR) ? !zero_flag : zero_flag;
        state_d  = S_IF;
        retire   = 1'b1;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        state_d  = S_IF;
        retire   = 1'b1;
      end
      S_TRAP: begin
        bus_error = 1'b1;
        state_d   = S_TRAP;
      end
      default: state_d = S_IF;
    endcase

    // Stall freezes progress and side effects; mux selects keep following the state.
    if (stall) begin
      state_d              = state_q;
      retire               = 1'b0;
      MemRead              = 1'b0;
      MemWrite             = 1'b0;
      IRWrite              = 1'b0;
      PCWrite              = 1'b0;
      RegWrite             = 1'b0;
      alu_start            = 1'b0;
      writeback_alu_enable = 1'b0;
      illegal_op           = 1'b0;
    end

    wait_d = wait_q;
    if (!stall) begin
      if ((state_d != state_q) || mem_ready)
        wait_d = '0;
      else if ((MEM_TIMEOUT != 0) && ((state_q == S_IF) || (state_q == S_MAC)))
        wait_d = wait_q + 1'b1;
    end

    // A done pulse that lands while stalled in EXEC_WAIT is remembered until we leave.
    done_d = done_q;
    if ((state_q == S_EXEC_WAIT) && alu_done) done_d = 1'b1;
    if (state_d != S_EXEC_WAIT)               done_d = 1'b0;

    if (!reboot_n) begin
      MemRead              = 1'b0;
      MemWrite             = 1'b0;
      ALUSrcA              = 1'b0;
      IorD                 = 1'b0;
      IRWrite              = 1'b0;
      ALUSrcB              = 2'b00;
      ALUOp                = '0;
      PCWrite              = 1'b0;
      PCSource             = 2'b00;
      RegWrite             = 1'b0;
      MemtoReg             = 1'b0;
      writeback_alu_enable = 1'b0;
      alu_start            = 1'b0;
      illegal_op           = 1'b0;
      bus_error            = 1'b0;
    end
  end

  assign state_o = state_q;

`ifdef FSM_CONTROL_PERF_CNT_EN
  logic [CNT_W-1:0] retired_q, cycle_q;

  always_ff @(posedge clk or negedge reboot_n) begin
    if (!reboot_n) begin
      retired_q <= '0;
      cycle_q   <= '0;
    end else begin
      if (retire) retired_q <= retired_q + 1'b1;
      if (!stall && (state_q != S_TRAP)) cycle_q <= cycle_q + 1'b1;
    end
  end

  assign retired_count = retired_q;
  assign cycle_count   = cycle_q;
`else
  logic perf_unused;
  assign perf_unused   = retire;
  assign retired_count = '0;
  assign cycle_count   = '0;
`endif

endmodule
